// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: state codes,
// ALUOp values agreed with the ALU control decoder, operand selects and opcodes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_EXEC_I   = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control table for the multi-cycle CPU.
// Only FETCH looks at mem_ready; only pc_en looks at zero.
module multicycle_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            // PC + imm computed early so BRANCH can load the target from ALUOut
            S_DECODE: alu_src_b = SRCB_IMM;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            // addi forces add: imm bit 30 would otherwise look like funct7 of sub
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32I-subset CPU: state register and
// next-state logic; control outputs come from multicycle_ctrl_decode.
module multicycle_main_control
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_instr,
    output logic [3:0] state
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        illegal_instr = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_mem_op(opcode))        state_d = S_MEM_ADDR;
                else if (opcode == OP_RTYPE)  state_d = S_EXEC_R;
                else if (opcode == OP_ITYPE)  state_d = S_EXEC_I;
                else if (opcode == OP_BRANCH) state_d = S_BRANCH;
                else begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            // IR is stable here; the FETCH fallback only guards a corrupted IR
            S_MEM_ADDR: begin
                if (opcode == OP_LOAD)       state_d = S_MEM_RD;
                else if (opcode == OP_STORE) state_d = S_MEM_WR;
                else                         state_d = S_FETCH;
            end
            S_MEM_RD: if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R: state_d = S_ALU_WB;
            S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .zero          (zero),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_en         (pc_en),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op)
    );

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: steps through each instruction
// class and checks the state and the full control-output word every cycle.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, pc_en, pc_source, i_or_d;
    logic       mem_read, mem_write, ir_write, mem_to_reg, reg_write;
    logic       alu_src_a, illegal_instr;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // Output word, MSB first:
    // pc_write pc_write_cond pc_en pc_source | i_or_d mem_read mem_write ir_write |
    // mem_to_reg reg_write alu_src_a alu_src_b[1] | alu_src_b[0] alu_op[1:0] illegal_instr
    localparam logic [15:0] O_IDLE    = 16'h0000;
    localparam logic [15:0] O_FETCH   = 16'hA508;
    localparam logic [15:0] O_FSTALL  = 16'h0408;
    localparam logic [15:0] O_DECODE  = 16'h0010;
    localparam logic [15:0] O_ILLEGAL = 16'h0011;
    localparam logic [15:0] O_MADDR   = 16'h0030;
    localparam logic [15:0] O_MEMRD   = 16'h0C00;
    localparam logic [15:0] O_MEMWB   = 16'h00C0;
    localparam logic [15:0] O_MEMWR   = 16'h0A00;
    localparam logic [15:0] O_EXECR   = 16'h0024;
    localparam logic [15:0] O_EXECI   = 16'h0030;
    localparam logic [15:0] O_ALUWB   = 16'h0040;
    localparam logic [15:0] O_BR_T    = 16'h7022;
    localparam logic [15:0] O_BR_N    = 16'h5022;

    logic [15:0] outs;
    assign outs = {pc_write, pc_write_cond, pc_en, pc_source,
                   i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_instr};

    multicycle_main_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_en         (pc_en),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag, input logic [3:0] es, input logic [15:0] eo);
        check({tag, " state"}, {28'd0, state}, {28'd0, es});
        check({tag, " outs"}, {16'd0, outs}, {16'd0, eo});
        check({tag, " rd_wr_excl"}, {31'd0, mem_read & mem_write}, 32'd0);
        check({tag, " wb_pc_excl"}, {31'd0, reg_write & pc_en}, 32'd0);
    endtask

    // Drive inputs at the falling edge, check 1 ns later, well clear of the rising edge.
    task automatic step(input string tag, input logic [6:0] op, input logic rdy,
                        input logic z, input logic [3:0] es, input logic [15:0] eo);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        #1;
        check_now(tag, es, eo);
    endtask

    initial begin
        // reset held for 3 cycles, inputs busy to show they are ignored
        step("reset0", LW, 1'b1, 1'b1, 4'd0, O_IDLE);
        step("reset1", SW, 1'b1, 1'b1, 4'd0, O_IDLE);
        step("reset2", R,  1'b1, 1'b1, 4'd0, O_IDLE);
        rst_n = 1'b1;
        #1;
        check_now("post_release_idle", 4'd0, O_IDLE);

        // R-type
        step("r_fetch",  R,   1'b1, 1'b0, 4'd1, O_FETCH);
        step("r_decode", R,   1'b1, 1'b0, 4'd2, O_DECODE);
        step("r_exec",   SW,  1'b0, 1'b0, 4'd7, O_EXECR);
        step("r_wb",     BAD, 1'b0, 1'b0, 4'd8, O_ALUWB);

        // lw with 2 stall cycles in MEM_RD: 7 cycles FETCH..MEM_WB
        step("lw_fetch",  LW, 1'b1, 1'b0, 4'd1, O_FETCH);
        step("lw_decode", LW, 1'b1, 1'b0, 4'd2, O_DECODE);
        step("lw_maddr",  LW, 1'b1, 1'b0, 4'd3, O_MADDR);
        step("lw_rd0",    R,  1'b0, 1'b0, 4'd4, O_MEMRD);
        step("lw_rd1",    R,  1'b0, 1'b0, 4'd4, O_MEMRD);
        step("lw_rd2",    R,  1'b1, 1'b0, 4'd4, O_MEMRD);
        step("lw_wb",     R,  1'b0, 1'b0, 4'd5, O_MEMWB);

        // fetch stall then addi
        step("i_fstall", I, 1'b0, 1'b0, 4'd1, O_FSTALL);
        step("i_fetch",  I, 1'b1, 1'b0, 4'd1, O_FETCH);
        step("i_decode", I, 1'b1, 1'b0, 4'd2, O_DECODE);
        step("i_exec",   I, 1'b0, 1'b0, 4'd10, O_EXECI);
        step("i_wb",     I, 1'b0, 1'b0, 4'd8, O_ALUWB);

        // beq taken, then not taken
        step("bt_fetch",  BEQ, 1'b1, 1'b0, 4'd1, O_FETCH);
        step("bt_decode", BEQ, 1'b1, 1'b0, 4'd2, O_DECODE);
        step("bt_branch", BEQ, 1'b1, 1'b1, 4'd9, O_BR_T);
        step("bn_fetch",  BEQ, 1'b1, 1'b0, 4'd1, O_FETCH);
        step("bn_decode", BEQ, 1'b1, 1'b0, 4'd2, O_DECODE);
        step("bn_branch", BEQ, 1'b1, 1'b0, 4'd9, O_BR_N);

        // sw, no stall
        step("sw_fetch",  SW, 1'b1, 1'b0, 4'd1, O_FETCH);
        step("sw_decode", SW, 1'b1, 1'b0, 4'd2, O_DECODE);
        step("sw_maddr",  SW, 1'b1, 1'b0, 4'd3, O_MADDR);
        step("sw_wr",     LW, 1'b1, 1'b0, 4'd6, O_MEMWR);

        // illegal opcode: single pulse in DECODE, back to FETCH
        step("ill_fetch",  BAD, 1'b1, 1'b0, 4'd1, O_FETCH);
        step("ill_decode", BAD, 1'b1, 1'b0, 4'd2, O_ILLEGAL);
        step("ill_after",  BAD, 1'b1, 1'b0, 4'd1, O_FETCH);

        // sw stalled in MEM_WR, then reset mid-access
        step("rs_decode", SW, 1'b1, 1'b0, 4'd2, O_DECODE);
        step("rs_maddr",  SW, 1'b1, 1'b0, 4'd3, O_MADDR);
        step("rs_wr",     SW, 1'b0, 1'b0, 4'd6, O_MEMWR);
        rst_n = 1'b0;
        #1;
        check_now("rs_async", 4'd0, O_IDLE);
        step("rs_held", SW, 1'b1, 1'b0, 4'd0, O_IDLE);
        rst_n = 1'b1;
        step("rs_fetch",  R, 1'b1, 1'b0, 4'd1, O_FETCH);
        step("rs_decode2", R, 1'b1, 1'b0, 4'd2, O_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
